// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, opcodes, instruction fields and ID/EX payload type
package id_ex_stage_pkg;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;
  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_LOAD    = 2'b10,
    CLS_STORE   = 2'b11
  } cls_e;
  localparam int CLS_HI = 31;
  localparam int CLS_LO = 30;
  localparam int OP_HI  = 29;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 17;
  localparam int RS2_HI = 16;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;
  typedef struct packed {
    logic [2:0]         opcode;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic [RADDR_W-1:0] rd;
    logic               wr_en;
    logic               is_load;
    logic               is_store;
    logic [XLEN-1:0]    store_data;
  } ex_payload_t;
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: instruction-in and EX-out handshake bundle of the issue stage
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic               ex_valid;
  logic               ex_ready;
  logic [2:0]         ex_opcode;
  logic [XLEN-1:0]    ex_op_a;
  logic [XLEN-1:0]    ex_op_b;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_wr_en;
  logic               ex_is_load;
  logic               ex_is_store;
  logic [XLEN-1:0]    ex_store_data;
  modport master (
    input  in_valid, in_instr, ex_ready,
    output in_ready, ex_valid, ex_opcode, ex_op_a, ex_op_b, ex_rd,
           ex_wr_en, ex_is_load, ex_is_store, ex_store_data
  );
  modport slave (
    output in_valid, in_instr, ex_ready,
    input  in_ready, ex_valid, ex_opcode, ex_op_a, ex_op_b, ex_rd,
           ex_wr_en, ex_is_load, ex_is_store, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// operand_fwd_mux: picks the freshest value of one source register (MEM > WB > regfile, r0 = 0)
module operand_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [RADDR_W-1:0] rs,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    value
);
  // younger producer wins; r0 never forwards
  always_comb value = (rs == '0) ? '0 :
                      (mem_wr_en && mem_rd == rs) ? mem_data :
                      (wb_wr_en && wb_rd == rs) ? wb_data : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, operand forwarding, load-use stall and ID/EX pipeline register
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  output logic [RADDR_W-1:0] rf_rs1_addr,
  output logic [RADDR_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]    rf_rs1_data,
  input  logic [XLEN-1:0]    rf_rs2_data,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_is_load,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  id_ex_stage_if.master      bus
);
  cls_e               cls;
  logic [2:0]         op;
  logic [RADDR_W-1:0] rd, rs1, rs2;
  logic [11:0]        imm;
  logic               rs2_used, haz1, haz2, hazard, adv, take;
  logic [XLEN-1:0]    fwd1, fwd2;
  ex_payload_t        new_payload, payload_d, payload_q;
  logic               ex_valid_d, ex_valid_q;
  // split the instruction word into its fields
  always_comb begin
    cls = cls_e'(bus.in_instr[CLS_HI:CLS_LO]);
    op  = bus.in_instr[OP_HI:OP_LO];
    rd  = bus.in_instr[RD_HI:RD_LO];
    rs1 = bus.in_instr[RS1_HI:RS1_LO];
    rs2 = bus.in_instr[RS2_HI:RS2_LO];
    imm = bus.in_instr[IMM_HI:IMM_LO];
    rs2_used = (cls == CLS_ALU_REG) || (cls == CLS_STORE);
  end
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;
  operand_fwd_mux u_fwd1 (
    .rs(rs1), .rf_data(rf_rs1_data),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(fwd1)
  );
  operand_fwd_mux u_fwd2 (
    .rs(rs2), .rf_data(rf_rs2_data),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(fwd2)
  );
  // load-use: a load in EX or MEM cannot forward yet, so the consumer must wait
  always_comb begin
    haz1 = (rs1 != '0) &&
           ((ex_valid_q && payload_q.is_load && payload_q.rd == rs1) ||
            (mem_is_load && mem_wr_en && mem_rd == rs1));
    haz2 = rs2_used && (rs2 != '0) &&
           ((ex_valid_q && payload_q.is_load && payload_q.rd == rs2) ||
            (mem_is_load && mem_wr_en && mem_rd == rs2));
    hazard = bus.in_valid && (haz1 || haz2);
    adv = !ex_valid_q || bus.ex_ready;
    take = !flush && adv && bus.in_valid && !hazard;
    bus.in_ready = adv && !hazard && !flush;
  end
  // build the EX payload; memory ops reuse the adder for address generation
  always_comb begin
    new_payload = '0;
    new_payload.opcode = cls[1] ? OP_ADD : op;
    new_payload.op_a = fwd1;
    new_payload.op_b = (cls == CLS_ALU_REG) ? fwd2 : sext12(imm);
    new_payload.rd = rd;
    new_payload.wr_en = (cls != CLS_STORE) && (rd != '0);
    new_payload.is_load = cls == CLS_LOAD;
    new_payload.is_store = cls == CLS_STORE;
    new_payload.store_data = (cls == CLS_STORE) ? fwd2 : '0;
    payload_d = take ? new_payload : payload_q;
    ex_valid_d = flush ? 1'b0 : adv ? take : ex_valid_q;
  end
  // ID/EX register: holds bit-for-bit while EX back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_q <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      payload_q <= payload_d;
      ex_valid_q <= ex_valid_d;
    end
  end
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_opcode     = payload_q.opcode;
  assign bus.ex_op_a       = payload_q.op_a;
  assign bus.ex_op_b       = payload_q.op_b;
  assign bus.ex_rd         = payload_q.rd;
  assign bus.ex_wr_en      = payload_q.wr_en;
  assign bus.ex_is_load    = payload_q.is_load;
  assign bus.ex_is_store   = payload_q.is_store;
  assign bus.ex_store_data = payload_q.store_data;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, forwarding, stalls, flush and reset
module tb_id_ex_stage;
  logic        clk, rst_n, flush;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        mem_wr_en, mem_is_load, wb_wr_en;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic [31:0] rf [32];
  int          n_chk, n_fail;
  id_ex_stage_if bus ();
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus(bus)
  );
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] enc(input logic [1:0] c, input logic [2:0] o,
                                      input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [11:0] im);
    return {c, o, d, s1, s2, im};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst_n = 1'b0;
    flush = 1'b0;
    mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_rd = '0; mem_data = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.ex_ready = 1'b1;
    #3;
    check("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("rst_op_a", bus.ex_op_a, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    bus.in_instr = enc(2'b00, 3'b000, 5'd3, 5'd1, 5'd2, 12'h0);
    bus.in_valid = 1'b1;
    check("t1_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step;
    check("t1_valid", {31'b0, bus.ex_valid}, 32'h1);
    check("t1_opcode", {29'b0, bus.ex_opcode}, 32'h0);
    check("t1_op_a", bus.ex_op_a, 32'd5);
    check("t1_op_b", bus.ex_op_b, 32'd7);
    check("t1_rd", {27'b0, bus.ex_rd}, 32'd3);
    check("t1_wr_en", {31'b0, bus.ex_wr_en}, 32'h1);
    bus.in_valid = 1'b0;
    step;
    check("t1_bubble", {31'b0, bus.ex_valid}, 32'h0);
    rf[1] = 32'h33;
    mem_wr_en = 1'b1; mem_rd = 5'd1; mem_data = 32'h11;
    wb_wr_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h22;
    bus.in_valid = 1'b1;
    step;
    check("t2_mem_fwd", bus.ex_op_a, 32'h11);
    check("t2_rs2_rf", bus.ex_op_b, 32'd7);
    mem_wr_en = 1'b0;
    step;
    check("t2_wb_fwd", bus.ex_op_a, 32'h22);
    wb_wr_en = 1'b0;
    bus.in_instr = enc(2'b10, 3'b110, 5'd4, 5'd1, 5'd0, 12'h008);
    step;
    check("t3_ld_valid", {31'b0, bus.ex_valid}, 32'h1);
    check("t3_ld_is_load", {31'b0, bus.ex_is_load}, 32'h1);
    check("t3_ld_opcode", {29'b0, bus.ex_opcode}, 32'h0);
    check("t3_ld_op_a", bus.ex_op_a, 32'h33);
    check("t3_ld_op_b", bus.ex_op_b, 32'h8);
    bus.in_instr = enc(2'b01, 3'b000, 5'd5, 5'd1, 5'd4, 12'h001);
    #1;
    check("t3_imm_no_rs2_haz", {31'b0, bus.in_ready}, 32'h1);
    bus.in_instr = enc(2'b00, 3'b000, 5'd5, 5'd4, 5'd4, 12'h0);
    #1;
    check("t3_stall_ex", {31'b0, bus.in_ready}, 32'h0);
    step;
    check("t3_bubble1", {31'b0, bus.ex_valid}, 32'h0);
    mem_is_load = 1'b1; mem_wr_en = 1'b1; mem_rd = 5'd4; mem_data = 32'h0;
    #1;
    check("t3_stall_mem", {31'b0, bus.in_ready}, 32'h0);
    step;
    check("t3_bubble2", {31'b0, bus.ex_valid}, 32'h0);
    mem_is_load = 1'b0; mem_wr_en = 1'b0;
    wb_wr_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    #1;
    check("t3_release", {31'b0, bus.in_ready}, 32'h1);
    step;
    check("t3_use_valid", {31'b0, bus.ex_valid}, 32'h1);
    check("t3_use_op_a", bus.ex_op_a, 32'h44);
    check("t3_use_op_b", bus.ex_op_b, 32'h44);
    check("t3_use_rd", {27'b0, bus.ex_rd}, 32'd5);
    wb_wr_en = 1'b0;
    bus.in_instr = enc(2'b00, 3'b001, 5'd6, 5'd1, 5'd2, 12'h0);
    step;
    bus.ex_ready = 1'b0;
    bus.in_instr = enc(2'b00, 3'b100, 5'd7, 5'd2, 5'd1, 12'h0);
    #1;
    check("t4_in_ready_held", {31'b0, bus.in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("t4_hold_valid", {31'b0, bus.ex_valid}, 32'h1);
      check("t4_hold_opcode", {29'b0, bus.ex_opcode}, 32'h1);
      check("t4_hold_op_a", bus.ex_op_a, 32'h33);
      check("t4_hold_op_b", bus.ex_op_b, 32'd7);
      check("t4_hold_rd", {27'b0, bus.ex_rd}, 32'd6);
    end
    bus.ex_ready = 1'b1;
    #1;
    check("t4_in_ready_rel", {31'b0, bus.in_ready}, 32'h1);
    step;
    check("t4_next_opcode", {29'b0, bus.ex_opcode}, 32'h4);
    check("t4_next_op_a", bus.ex_op_a, 32'd7);
    check("t4_next_op_b", bus.ex_op_b, 32'h33);
    check("t4_next_rd", {27'b0, bus.ex_rd}, 32'd7);
    bus.in_instr = enc(2'b00, 3'b111, 5'd8, 5'd1, 5'd2, 12'h0);
    flush = 1'b1;
    #1;
    check("t5_in_ready_flush", {31'b0, bus.in_ready}, 32'h0);
    step;
    check("t5_flushed", {31'b0, bus.ex_valid}, 32'h0);
    flush = 1'b0;
    step;
    check("t5_kept_valid", {31'b0, bus.ex_valid}, 32'h1);
    check("t5_kept_opcode", {29'b0, bus.ex_opcode}, 32'h7);
    check("t5_kept_rd", {27'b0, bus.ex_rd}, 32'd8);
    rf[0] = 32'hDEAD;
    bus.in_instr = enc(2'b01, 3'b000, 5'd9, 5'd0, 5'd0, 12'hFFF);
    step;
    check("t6_r0_op_a", bus.ex_op_a, 32'h0);
    check("t6_sext_op_b", bus.ex_op_b, 32'hFFFFFFFF);
    check("t6_rd", {27'b0, bus.ex_rd}, 32'd9);
    bus.in_instr = enc(2'b11, 3'b101, 5'd0, 5'd1, 5'd2, 12'h004);
    step;
    check("t6_st_opcode", {29'b0, bus.ex_opcode}, 32'h0);
    check("t6_st_op_a", bus.ex_op_a, 32'h33);
    check("t6_st_op_b", bus.ex_op_b, 32'h4);
    check("t6_st_wr_en", {31'b0, bus.ex_wr_en}, 32'h0);
    check("t6_st_is_store", {31'b0, bus.ex_is_store}, 32'h1);
    check("t6_st_data", bus.ex_store_data, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("t6_arst_op_b", bus.ex_op_b, 32'h0);
    check("t6_arst_store", {31'b0, bus.ex_is_store}, 32'h0);
    check("t6_arst_data", bus.ex_store_data, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    check("t6_post_rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
